// File: rtl/sr_latch_driver.sv
// Command sequencer driving an SR latch's S/R inputs and reading back Q/Qbar.
// Ports: cmd valid/ready/op in, rsp valid/ready/q/err out, S/R out, Q/Qbar in.
module sr_latch_driver #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       S,
  output logic       R,
  input  logic       Q,
  input  logic       Qbar
);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    SETTLE,
    CHECK,
    RESP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PULSE_LD  =
    CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LD =
    CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [1:0]           q_sync_q;
  logic [1:0]           qb_sync_q;
  logic                 exp_q;
  logic                 smp_q;
  logic                 s_q;
  logic                 r_q;
  logic                 rdy_q;
  logic                 vld_q;
  logic                 rq_q;
  logic                 err_q;
  logic                 q_s;
  logic                 qb_s;
  logic                 chk_err;

  assign q_s  = q_sync_q[1];
  assign qb_s = qb_sync_q[1];

  // Sample only checks complementarity; other ops also check the target.
  assign chk_err = (q_s == qb_s) | (~smp_q & (q_s != exp_q));

  assign S         = s_q;
  assign R         = r_q;
  assign cmd_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_q     = rq_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_sync_q  <= '0;
      qb_sync_q <= '0;
      exp_q     <= 1'b0;
      smp_q     <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      rq_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_sync_q  <= {q_sync_q[0], Q};
      qb_sync_q <= {qb_sync_q[0], Qbar};
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && rdy_q) begin
            rdy_q <= 1'b0;
            smp_q <= (cmd_op == 2'b00);
            cnt_q <= PULSE_LD;
            unique case (cmd_op)
              2'b00: begin
                state_q <= CHECK;
              end
              2'b01: begin
                exp_q   <= 1'b1;
                s_q     <= 1'b1;
                state_q <= PULSE;
              end
              2'b10: begin
                exp_q   <= 1'b0;
                r_q     <= 1'b1;
                state_q <= PULSE;
              end
              default: begin
                // Toggle drives toward the complement of the current Q.
                exp_q   <= ~q_s;
                s_q     <= ~q_s;
                r_q     <= q_s;
                state_q <= PULSE;
              end
            endcase
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            cnt_q   <= SETTLE_LD;
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CHECK: begin
          rq_q    <= q_s;
          err_q   <= chk_err;
          vld_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch model.
// Instance 0 uses default timing, instance 1 uses PULSE=1 / SETTLE=15.
module tb_sr_latch_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid_a [2];
  logic       cmd_ready_a [2];
  logic [1:0] cmd_op_a    [2];
  logic       rsp_valid_a [2];
  logic       rsp_ready_a [2];
  logic       rsp_q_a     [2];
  logic       rsp_err_a   [2];
  logic       S_a         [2];
  logic       R_a         [2];
  logic       Q_a         [2];
  logic       Qbar_a      [2];

  logic lq0 = 1'b0;
  logic lq1 = 1'b0;
  int   fault = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sr_latch_driver dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid_a[0]),
    .cmd_ready (cmd_ready_a[0]),
    .cmd_op    (cmd_op_a[0]),
    .rsp_valid (rsp_valid_a[0]),
    .rsp_ready (rsp_ready_a[0]),
    .rsp_q     (rsp_q_a[0]),
    .rsp_err   (rsp_err_a[0]),
    .S         (S_a[0]),
    .R         (R_a[0]),
    .Q         (Q_a[0]),
    .Qbar      (Qbar_a[0])
  );

  sr_latch_driver #(
    .PULSE_CYCLES  (1),
    .SETTLE_CYCLES (15),
    .CNT_WIDTH     (4)
  ) dut2 (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid_a[1]),
    .cmd_ready (cmd_ready_a[1]),
    .cmd_op    (cmd_op_a[1]),
    .rsp_valid (rsp_valid_a[1]),
    .rsp_ready (rsp_ready_a[1]),
    .rsp_q     (rsp_q_a[1]),
    .rsp_err   (rsp_err_a[1]),
    .S         (S_a[1]),
    .R         (R_a[1]),
    .Q         (Q_a[1]),
    .Qbar      (Qbar_a[1])
  );

  // Latch models; fault 1 = Q stuck 0, fault 2 = Q and Qbar both 1.
  always @(posedge S_a[0]) lq0 = 1'b1;
  always @(posedge R_a[0]) lq0 = 1'b0;
  always @(posedge S_a[1]) lq1 = 1'b1;
  always @(posedge R_a[1]) lq1 = 1'b0;

  assign Q_a[0]    = (fault == 1) ? 1'b0 :
                     (fault == 2) ? 1'b1 : lq0;
  assign Qbar_a[0] = (fault != 0) ? 1'b1 : ~lq0;
  assign Q_a[1]    = lq1;
  assign Qbar_a[1] = ~lq1;

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (S_a[d] && R_a[d]) begin
        errors++;
        $display("FAIL s_and_r dut%0d act=1 exp=0 t=%0t", d, $time);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_cmd(input int d, input logic [1:0] op,
                         output int lat, output logic q,
                         output logic err, output int sc,
                         output int rc);
    int g;
    g = 0;
    @(negedge clock);
    while (!cmd_ready_a[d] && g < 100) begin
      @(negedge clock);
      g++;
    end
    cmd_op_a[d]    = op;
    cmd_valid_a[d] = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid_a[d] = 1'b0;
    lat = 0;
    sc  = 0;
    rc  = 0;
    if (S_a[d]) sc++;
    if (R_a[d]) rc++;
    while (!rsp_valid_a[d] && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (S_a[d]) sc++;
      if (R_a[d]) rc++;
    end
    q   = rsp_q_a[d];
    err = rsp_err_a[d];
  endtask

  typedef struct {
    logic [1:0] op;
    int         fault;
    int         lat;
    int         sc;
    int         rc;
    logic       q;
    logic       err;
  } vec_t;

  vec_t tv[10];

  initial begin
    int   lat;
    int   sc;
    int   rc;
    int   bad;
    int   m;
    logic q;
    logic err;
    logic [1:0] op;

    tv[0] = '{2'b01, 0, 5, 2, 0, 1'b1, 1'b0};
    tv[1] = '{2'b00, 0, 1, 0, 0, 1'b1, 1'b0};
    tv[2] = '{2'b11, 0, 5, 0, 2, 1'b0, 1'b0};
    tv[3] = '{2'b11, 0, 5, 2, 0, 1'b1, 1'b0};
    tv[4] = '{2'b10, 0, 5, 0, 2, 1'b0, 1'b0};
    tv[5] = '{2'b00, 0, 1, 0, 0, 1'b0, 1'b0};
    tv[6] = '{2'b01, 1, 5, 2, 0, 1'b0, 1'b1};
    tv[7] = '{2'b00, 2, 1, 0, 0, 1'b1, 1'b1};
    tv[8] = '{2'b11, 1, 5, 2, 0, 1'b0, 1'b1};
    tv[9] = '{2'b10, 0, 5, 0, 2, 1'b0, 1'b0};

    for (int d = 0; d < 2; d++) begin
      cmd_valid_a[d] = 1'b0;
      cmd_op_a[d]    = 2'b00;
      rsp_ready_a[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_cmd_ready", int'(cmd_ready_a[0]), 1);
    chk("rst_rsp_valid", int'(rsp_valid_a[0]), 0);
    chk("rst_s", int'(S_a[0]), 0);
    chk("rst_r", int'(R_a[0]), 0);
    chk("rst_rsp_q", int'(rsp_q_a[0]), 0);
    chk("rst_rsp_err", int'(rsp_err_a[0]), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Reset while S is high drops S with no clock edge.
    cmd_op_a[0]    = 2'b01;
    cmd_valid_a[0] = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid_a[0] = 1'b0;
    chk("pulse_s_high", int'(S_a[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_s", int'(S_a[0]), 0);
    chk("mid_rst_r", int'(R_a[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    chk("post_rst_ready", int'(cmd_ready_a[0]), 1);
    chk("post_rst_valid", int'(rsp_valid_a[0]), 0);
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (rsp_valid_a[0] || S_a[0]) bad++;
    end
    chk("abandoned_cmd", bad, 0);

    for (int i = 0; i < 10; i++) begin
      fault = tv[i].fault;
      repeat (3) @(negedge clock);
      run_cmd(0, tv[i].op, lat, q, err, sc, rc);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_s_cyc", i), sc, tv[i].sc);
      chk($sformatf("v%0d_r_cyc", i), rc, tv[i].rc);
      chk($sformatf("v%0d_q", i), int'(q), int'(tv[i].q));
      chk($sformatf("v%0d_err", i), int'(err), int'(tv[i].err));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_idle", i),
          int'(!rsp_valid_a[0] && cmd_ready_a[0]), 1);
    end

    // Backpressure with a new command waiting.
    fault = 0;
    rsp_ready_a[0] = 1'b0;
    repeat (3) @(negedge clock);
    run_cmd(0, 2'b01, lat, q, err, sc, rc);
    chk("bp_lat", lat, 5);
    chk("bp_q", int'(q), 1);
    chk("bp_err", int'(err), 0);
    cmd_op_a[0]    = 2'b00;
    cmd_valid_a[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("bp_hold%0d", k),
          int'(rsp_valid_a[0] && rsp_q_a[0] &&
               !rsp_err_a[0] && !cmd_ready_a[0]), 1);
    end
    @(negedge clock);
    rsp_ready_a[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_hs_valid", int'(rsp_valid_a[0]), 0);
    chk("bp_hs_ready", int'(cmd_ready_a[0]), 1);
    chk("bp_keep_q", int'(rsp_q_a[0]), 1);
    @(posedge clock);
    #1;
    cmd_valid_a[0] = 1'b0;
    chk("bp_next_acc", int'(cmd_ready_a[0]), 0);
    @(posedge clock);
    #1;
    chk("bp_next_rsp", int'(rsp_valid_a[0]), 1);
    chk("bp_next_q", int'(rsp_q_a[0]), 1);
    @(posedge clock);
    #1;

    // Short pulse, long settle instance.
    repeat (3) @(negedge clock);
    run_cmd(1, 2'b01, lat, q, err, sc, rc);
    chk("p1_lat", lat, 17);
    chk("p1_s_cyc", sc, 1);
    chk("p1_r_cyc", rc, 0);
    chk("p1_q", int'(q), 1);
    chk("p1_err", int'(err), 0);
    m = 1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      run_cmd(1, op, lat, q, err, sc, rc);
      case (op)
        2'b01:   m = 1;
        2'b10:   m = 0;
        2'b11:   m = 1 - m;
        default: m = m;
      endcase
      chk($sformatf("r%0d_lat", i), lat,
          (op == 2'b00) ? 1 : 17);
      chk($sformatf("r%0d_q", i), int'(q), m);
      chk($sformatf("r%0d_err", i), int'(err), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
